adder_arbiter_50_20: RTL and testbench

Round-robin arbiter that shares a single 50-bit + 20-bit zero-extending adder datapath between two requesters, such as the multiply-accumulate path and the address/offset path. Each requester issues operands over a valid/ready handshake. The block registers the 51-bit sum and holds it in a per-port response register until the requester consumes it. It sits between the execute-stage requesters and the one shared `customAdder50_30` instance, so only one physical adder is needed.

---
 rtl/adder_arb_pkg.sv | 8 +
 rtl/customAdder50_30.sv | 12 +
 rtl/adder_arbiter_50_20.sv | 81 ++++++++
 tb/tb_adder_arbiter_50_20.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// Shared widths and types for the two-port arbiter around the 50+20 bit adder.
package adder_arb_pkg;
  localparam int ADDER_A_W = 50;
  localparam int ADDER_B_W = 20;
  localparam int ADDER_S_W = 51;

  typedef logic [0:0] port_id_t;
endpackage

// File: rtl/customAdder50_30.sv
// Shared unsigned adder: A plus zero-extended B, carry returned in the top bit.
module customAdder50_30
  import adder_arb_pkg::*;
(
  input  logic [ADDER_A_W-1:0] a,
  input  logic [ADDER_B_W-1:0] b,
  output logic [ADDER_S_W-1:0] sum
);

  assign sum = {1'b0, a} + {{(ADDER_S_W-ADDER_B_W){1'b0}}, b};

endmodule

// File: rtl/adder_arbiter_50_20.sv
// Round-robin arbiter sharing one adder between two valid/ready requesters,
// with a per-port response register held until the requester consumes it.
module adder_arbiter_50_20
  import adder_arb_pkg::*;
#(
  parameter int A_WIDTH = 50,
  parameter int B_WIDTH = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [A_WIDTH-1:0] req0_a,
  input  logic [B_WIDTH-1:0] req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [A_WIDTH-1:0] req1_a,
  input  logic [B_WIDTH-1:0] req1_b,
  output logic               resp0_valid,
  input  logic               resp0_ready,
  output logic [A_WIDTH:0]   resp0_sum,
  output logic               resp1_valid,
  input  logic               resp1_ready,
  output logic [A_WIDTH:0]   resp1_sum
);

  port_id_t            rr_ptr;
  logic                elig0;
  logic                elig1;
  logic                grant0;
  logic                grant1;
  logic [ADDER_A_W-1:0] add_a;
  logic [ADDER_B_W-1:0] add_b;
  logic [ADDER_S_W-1:0] add_sum;

  // A held response blocks its port even in the cycle it is being consumed.
  assign elig0 = req0_valid && !resp0_valid;
  assign elig1 = req1_valid && !resp1_valid;

  assign grant0 = !rst && elig0 && (!elig1 || (rr_ptr == 1'b0));
  assign grant1 = !rst && elig1 && (!elig0 || (rr_ptr == 1'b1));

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign add_a = grant1 ? req1_a : req0_a;
  assign add_b = grant1 ? req1_b : req0_b;

  customAdder50_30 u_adder (
    .a   (add_a),
    .b   (add_b),
    .sum (add_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= 1'b0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      resp0_sum   <= '0;
      resp1_sum   <= '0;
    end else begin
      if (grant0) begin
        resp0_sum   <= add_sum;
        resp0_valid <= 1'b1;
        rr_ptr      <= 1'b1;
      end else if (resp0_valid && resp0_ready) begin
        resp0_valid <= 1'b0;
      end

      if (grant1) begin
        resp1_sum   <= add_sum;
        resp1_valid <= 1'b1;
        rr_ptr      <= 1'b0;
      end else if (resp1_valid && resp1_ready) begin
        resp1_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adder_arbiter_50_20.sv
// Directed bench for adder_arbiter_50_20: reset, single request, alternation,
// held response, same-cycle consume and mid-operation reset.
module tb_adder_arbiter_50_20;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [49:0] req0_a, req1_a;
  logic [19:0] req0_b, req1_b;
  logic        resp0_valid, resp1_valid;
  logic        resp0_ready, resp1_ready;
  logic [50:0] resp0_sum, resp1_sum;

  int total = 0;
  int bad   = 0;

  adder_arbiter_50_20 dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .resp0_valid (resp0_valid),
    .resp0_ready (resp0_ready),
    .resp0_sum   (resp0_sum),
    .resp1_valid (resp1_valid),
    .resp1_ready (resp1_ready),
    .resp1_sum   (resp1_sum)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid  = 1'b0;
    req1_valid  = 1'b0;
    req0_a      = '0;
    req1_a      = '0;
    req0_b      = '0;
    req1_b      = '0;
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 50'h10; req0_b = 20'h1;
    req1_a = 50'h20; req1_b = 20'h2;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      #1;
      total++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
        bad++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready});
      end
      total++;
      if ({resp0_valid, resp1_valid} !== 2'b00) begin
        bad++; $display("FAIL reset_resp_valid got=%b exp=00", {resp0_valid, resp1_valid});
      end
      total++;
      if (resp0_sum !== 51'h0 || resp1_sum !== 51'h0) begin
        bad++; $display("FAIL reset_sums got=%h/%h exp=0/0", resp0_sum, resp1_sum);
      end
    end
    rst = 1'b0;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++; $display("FAIL reset_first_grant got=%b exp=10", {req0_ready, req1_ready});
    end
    step();
    total++;
    if (resp0_valid !== 1'b1 || resp0_sum !== 51'h11) begin
      bad++; $display("FAIL reset_first_sum got=%b/%h exp=1/11", resp0_valid, resp0_sum);
    end
  endtask

  task automatic test_single();
    do_reset();
    req0_valid = 1'b1;
    req0_a = 50'h3_FFFF_FFFF_FFFF;
    req0_b = 20'hFFFFF;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++; $display("FAIL single_ready got=%b exp=10", {req0_ready, req1_ready});
    end
    step();
    req0_valid = 1'b0;
    #1;
    total++;
    if (resp0_valid !== 1'b1 || resp1_valid !== 1'b0) begin
      bad++; $display("FAIL single_valid got=%b%b exp=10", resp0_valid, resp1_valid);
    end
    total++;
    if (resp0_sum !== 51'h4_0000_000F_FFFE) begin
      bad++; $display("FAIL single_max_sum got=%h exp=4_0000_000f_fffe", resp0_sum);
    end
  endtask

  task automatic test_alternate();
    int          exp_port;
    logic [50:0] exp_sum;
    do_reset();
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    req0_valid  = 1'b1; req1_valid  = 1'b1;
    req0_b = 20'd1; req1_b = 20'd1;
    for (int i = 0; i < 6; i++) begin
      req0_a = 50'(i * 1000 + 7);
      req1_a = 50'(i * 1000 + 9);
      #1;
      exp_port = i % 2;
      total++;
      if ({req0_ready, req1_ready} !== ((exp_port == 0) ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL alt_grant cyc=%0d got=%b exp_port=%0d", i, {req0_ready, req1_ready}, exp_port);
      end
      exp_sum = (exp_port == 0) ? 51'(i * 1000 + 8) : 51'(i * 1000 + 10);
      step();
      total++;
      if (exp_port == 0) begin
        if (resp0_valid !== 1'b1 || resp0_sum !== exp_sum) begin
          bad++; $display("FAIL alt_sum0 cyc=%0d got=%b/%0d exp=1/%0d", i, resp0_valid, resp0_sum, exp_sum);
        end
      end else begin
        if (resp1_valid !== 1'b1 || resp1_sum !== exp_sum) begin
          bad++; $display("FAIL alt_sum1 cyc=%0d got=%b/%0d exp=1/%0d", i, resp1_valid, resp1_sum, exp_sum);
        end
      end
    end
  endtask

  task automatic test_hold();
    do_reset();
    req0_valid = 1'b1;
    req0_a = 50'h123; req0_b = 20'h10;
    step();
    req1_valid = 1'b1;
    req1_a = 50'h40; req1_b = 20'h2;
    resp0_ready = 1'b0; resp1_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      #1;
      total++;
      if (req0_ready !== 1'b0) begin
        bad++; $display("FAIL hold_ready0 cyc=%0d got=%b exp=0", j, req0_ready);
      end
      total++;
      if (req1_ready !== ((j % 2) == 0)) begin
        bad++; $display("FAIL hold_ready1 cyc=%0d got=%b exp=%b", j, req1_ready, (j % 2) == 0);
      end
      total++;
      if (resp0_valid !== 1'b1 || resp0_sum !== 51'h133) begin
        bad++; $display("FAIL hold_resp0 cyc=%0d got=%b/%h exp=1/133", j, resp0_valid, resp0_sum);
      end
      step();
    end
    total++;
    if (resp1_sum !== 51'h42) begin
      bad++; $display("FAIL hold_sum1 got=%h exp=42", resp1_sum);
    end
  endtask

  task automatic test_consume_same_cycle();
    do_reset();
    req1_valid = 1'b1;
    req1_a = 50'd5; req1_b = 20'd6;
    #1;
    total++;
    if (req1_ready !== 1'b1) begin
      bad++; $display("FAIL consume_first_grant got=%b exp=1", req1_ready);
    end
    step();
    resp1_ready = 1'b1;
    #1;
    total++;
    if (req1_ready !== 1'b0) begin
      bad++; $display("FAIL consume_blocked got=%b exp=0", req1_ready);
    end
    total++;
    if (resp1_valid !== 1'b1 || resp1_sum !== 51'd11) begin
      bad++; $display("FAIL consume_sum got=%b/%0d exp=1/11", resp1_valid, resp1_sum);
    end
    step();
    req1_a = 50'd20;
    resp1_ready = 1'b0;
    #1;
    total++;
    if (resp1_valid !== 1'b0 || req1_ready !== 1'b1) begin
      bad++; $display("FAIL consume_next_grant got=%b%b exp=01", resp1_valid, req1_ready);
    end
    step();
    total++;
    if (resp1_valid !== 1'b1 || resp1_sum !== 51'd26) begin
      bad++; $display("FAIL consume_second_sum got=%b/%0d exp=1/26", resp1_valid, resp1_sum);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    // Leave the pointer at 1, then reset and check port 0 is preferred again.
    req0_valid = 1'b1;
    req0_a = 50'h7; req0_b = 20'h1;
    step();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b1;
    #1;
    total++;
    if (req1_ready !== 1'b0) begin
      bad++; $display("FAIL mid_rst_ready got=%b exp=0", req1_ready);
    end
    step();
    rst = 1'b0;
    #1;
    total++;
    if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0 || resp0_sum !== 51'h0) begin
      bad++; $display("FAIL mid_rst_state got=%b%b/%h exp=00/0", resp0_valid, resp1_valid, resp0_sum);
    end
    req0_valid = 1'b1;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++; $display("FAIL mid_rst_rr got=%b exp=10", {req0_ready, req1_ready});
    end
    step();
    req0_valid = 1'b0;
    req1_a = 50'h30; req1_b = 20'h3;
    #1;
    total++;
    if (req1_ready !== 1'b1) begin
      bad++; $display("FAIL mid_grant1 got=%b exp=1", req1_ready);
    end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    req1_valid = 1'b0;
    #1;
    total++;
    if (resp1_valid !== 1'b0 || resp1_sum !== 51'h0) begin
      bad++; $display("FAIL mid_rst_resp1 got=%b/%h exp=0/0", resp1_valid, resp1_sum);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_single();
    test_alternate();
    test_hold();
    test_consume_same_cycle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
